// File: rtl/vga_timing_gen.sv
// 800x600@56 raster timing with a colour return path that is re-aligned to the
// sync pins and blanked outside the visible area.
module vga_timing_gen #(
  parameter int physical_width_p  = 800,
  parameter int physical_height_p = 600,
  parameter int h_front_p         = 24,
  parameter int h_sync_p          = 72,
  parameter int h_back_p          = 128,
  parameter int v_front_p         = 1,
  parameter int v_sync_p          = 2,
  parameter int v_back_p          = 22,
  parameter bit sync_pol_p        = 1'b1,
  parameter int bit_depth_p       = 1,
  parameter int pipe_delay_p      = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  output logic [$clog2(physical_width_p)-1:0]  vga_x_i,
  output logic [$clog2(physical_height_p)-1:0] vga_y_i,
  output logic                                 vga_v_i,
  input  logic [bit_depth_p-1:0]               vga_r_o,
  input  logic [bit_depth_p-1:0]               vga_g_o,
  input  logic [bit_depth_p-1:0]               vga_b_o,
  output logic [bit_depth_p-1:0]               r_o,
  output logic [bit_depth_p-1:0]               g_o,
  output logic [bit_depth_p-1:0]               b_o,
  output logic                                 hsync_o,
  output logic                                 vsync_o,
  output logic                                 de_o,
  output logic                                 frame_o
);

  localparam int HT = physical_width_p + h_front_p + h_sync_p + h_back_p;
  localparam int VT = physical_height_p + v_front_p + v_sync_p + v_back_p;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int XW = $clog2(physical_width_p);
  localparam int YW = $clog2(physical_height_p);
  localparam int D  = pipe_delay_p + 1;

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(physical_width_p);
  localparam logic [HW-1:0] HS_ON  = HW'(physical_width_p + h_front_p);
  localparam logic [HW-1:0] HS_OFF = HW'(physical_width_p + h_front_p + h_sync_p);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(physical_height_p);
  localparam logic [VW-1:0] VS_ON  = VW'(physical_height_p + v_front_p);
  localparam logic [VW-1:0] VS_OFF = VW'(physical_height_p + v_front_p + v_sync_p);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          vis, hs_raw, vs_raw, vis_pd;

  // {vsync, hsync, visible} per stage
  logic [2:0]             dly_q [D];
  logic [bit_depth_p-1:0] r_q, g_q, b_q;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign vis    = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_raw = (h_q >= HS_ON) && (h_q < HS_OFF);
  assign vs_raw = (v_q >= VS_ON) && (v_q < VS_OFF);

  assign vga_v_i = vis;
  assign vga_x_i = vis ? h_q[XW-1:0] : '0;
  assign vga_y_i = vis ? v_q[YW-1:0] : '0;
  assign frame_o = (h_q == '0) && (v_q == V_VIS);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < D; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {vs_raw, hs_raw, vis};
      for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Visible flag lined up with the colour currently arriving from upstream
  generate
    if (pipe_delay_p == 0) begin : g_nodly
      assign vis_pd = vis;
    end else begin : g_dly
      assign vis_pd = dly_q[pipe_delay_p-1][0];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= vis_pd ? vga_r_o : '0;
      g_q <= vis_pd ? vga_g_o : '0;
      b_q <= vis_pd ? vga_b_o : '0;
    end
  end

  assign r_o     = r_q;
  assign g_o     = g_q;
  assign b_o     = b_q;
  assign de_o    = dly_q[D-1][0];
  assign hsync_o = sync_pol_p ? dly_q[D-1][1] : ~dly_q[D-1][1];
  assign vsync_o = sync_pol_p ? dly_q[D-1][2] : ~dly_q[D-1][2];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines, a short 8-line visible frame
// (13 lines total) so two frames and a mid-frame reset stay short.
module tb_vga_timing_gen;

  localparam int W  = 800;
  localparam int H  = 8;
  localparam int LN = 1024;
  localparam int FR = 13 * LN;

  localparam int S_X = 0, S_Y = 1, S_V = 2, S_DE = 3, S_HS = 4;
  localparam int S_VS = 5, S_FR = 6, S_R = 7;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [9:0] vga_x_i;
  logic [2:0] vga_y_i;
  logic       vga_v_i;
  logic [0:0] vga_r_o, vga_g_o, vga_b_o;
  logic [0:0] r_o, g_o, b_o;
  logic       hsync_o, vsync_o, de_o, frame_o;

  vga_timing_gen #(
    .physical_width_p (W),
    .physical_height_p(H),
    .h_front_p        (24),
    .h_sync_p         (72),
    .h_back_p         (128),
    .v_front_p        (1),
    .v_sync_p         (2),
    .v_back_p         (2),
    .sync_pol_p       (1'b1),
    .bit_depth_p      (1),
    .pipe_delay_p     (1)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .vga_x_i(vga_x_i),
    .vga_y_i(vga_y_i),
    .vga_v_i(vga_v_i),
    .vga_r_o(vga_r_o),
    .vga_g_o(vga_g_o),
    .vga_b_o(vga_b_o),
    .r_o    (r_o),
    .g_o    (g_o),
    .b_o    (b_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .de_o   (de_o),
    .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cur = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d",
               nm, cur, act, req);
    end
  endtask

  task automatic push(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      S_X:     return 32'(vga_x_i);
      S_Y:     return 32'(vga_y_i);
      S_V:     return 32'(vga_v_i);
      S_DE:    return 32'(de_o);
      S_HS:    return 32'(hsync_o);
      S_VS:    return 32'(vsync_o);
      S_FR:    return 32'(frame_o);
      default: return 32'(r_o);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_X:     return "vga_x";
      S_Y:     return "vga_y";
      S_V:     return "vga_v";
      S_DE:    return "de";
      S_HS:    return "hsync";
      S_VS:    return "vsync";
      S_FR:    return "frame";
      default: return "r";
    endcase
  endfunction

  task automatic push_reset_vec();
    push(0, S_V, 1);
    push(0, S_X, 0);
    push(0, S_Y, 0);
    push(0, S_DE, 0);
    push(0, S_HS, 0);
    push(0, S_VS, 0);
    push(0, S_FR, 0);
    push(0, S_R, 0);
    push(1, S_X, 1);
    push(1, S_DE, 0);
    push(2, S_DE, 1);
  endtask

  // Upstream stage: colour for the previous cycle's coordinate
  initial begin
    logic [9:0] px;
    logic       pv;
    px = '0;
    pv = 1'b0;
    vga_r_o = '0;
    vga_g_o = '0;
    vga_b_o = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (reset_i) begin
        vga_r_o = 1'b1;
        vga_g_o = 1'b1;
        vga_b_o = 1'b1;
      end else begin
        vga_r_o = (pv && px == 10'd5) || !pv;
        vga_g_o = !pv;
        vga_b_o = !pv;
      end
      px = vga_x_i;
      pv = vga_v_i;
    end
  end

  // Monitor: pops directed expectations and checks pulse shapes
  initial begin
    int rst_n = 0;
    int didx = 0, hs_rise = -1, vs_rise = -1, fr_last = -1;
    int vcnt = 0, dcnt = 0, rcnt = 0;
    logic pde = 0, phs = 0, pvs = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        rst_n++;
        cyc = 0;
        didx = 0;
        hs_rise = -1;
        vs_rise = -1;
        fr_last = -1;
        vcnt = 0;
        dcnt = 0;
        rcnt = 0;
        pde = 0;
        phs = 0;
        pvs = 0;
        if (rst_n >= 2)
          chk("reset_state",
              32'({vga_v_i, vga_x_i, vga_y_i, de_o, r_o, g_o, b_o,
                   hsync_o, vsync_o, frame_o}),
              32'({1'b1, 10'd0, 3'd0, 7'd0}));
      end else begin
        rst_n = 0;
        cur = cyc;
        while (q.size() > 0 && q[0].cyc < cur) begin
          chk({"missed_", sig_name(q[0].sig)}, 32'hdead, 32'(q[0].val));
          void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].cyc == cur) begin
          chk(sig_name(q[0].sig), sig_val(q[0].sig), 32'(q[0].val));
          void'(q.pop_front());
        end
        if (de_o) didx = pde ? didx + 1 : 0;
        chk("rgb", 32'({r_o, g_o, b_o}),
            32'({de_o && didx == 5, 1'b0, 1'b0}));
        if (hsync_o && !phs) begin
          if (hs_rise < 0) chk("hs_first", cur, 826);
          else chk("hs_period", cur - hs_rise, LN);
          hs_rise = cur;
        end
        if (!hsync_o && phs) chk("hs_width", cur - hs_rise, 72);
        if (vsync_o && !pvs) begin
          if (vs_rise < 0) chk("vs_first", cur, 9 * LN + 2);
          else chk("vs_period", cur - vs_rise, FR);
          vs_rise = cur;
        end
        if (!vsync_o && pvs) chk("vs_width", cur - vs_rise, 2 * LN);
        if (frame_o) begin
          chk("frame_cyc", cur, (fr_last < 0) ? H * LN : fr_last + FR);
          chk("vis_per_frame", vcnt, W * H);
          chk("de_per_frame", dcnt, W * H);
          chk("r_per_frame", rcnt, H);
          fr_last = cur;
          vcnt = 0;
          dcnt = 0;
          rcnt = 0;
        end
        vcnt += int'(vga_v_i);
        dcnt += int'(de_o);
        rcnt += int'(r_o);
        pde = de_o;
        phs = hsync_o;
        pvs = vsync_o;
        cyc++;
      end
    end
  end

  initial begin
    int guard;
    reset_i = 1'b1;
    push_reset_vec();
    push(799, S_X, 799);
    push(799, S_V, 1);
    push(800, S_V, 0);
    push(800, S_X, 0);
    push(801, S_DE, 1);
    push(802, S_DE, 0);
    push(825, S_HS, 0);
    push(826, S_HS, 1);
    push(897, S_HS, 1);
    push(898, S_HS, 0);
    push(LN, S_Y, 1);
    push(LN, S_X, 0);
    push(LN, S_V, 1);
    push(7 * LN + 5, S_X, 5);
    push(7 * LN + 5, S_Y, 7);
    push(H * LN - 1, S_FR, 0);
    push(H * LN, S_FR, 1);
    push(H * LN, S_V, 0);
    push(H * LN + 1, S_FR, 0);
    push(9 * LN + 1, S_VS, 0);
    push(9 * LN + 2, S_VS, 1);
    push(10000, S_DE, 0);
    push(11 * LN + 1, S_VS, 1);
    push(11 * LN + 2, S_VS, 0);
    push(FR - 1, S_V, 0);
    push(FR, S_X, 0);
    push(FR, S_Y, 0);
    push(FR, S_V, 1);
    push(FR + 799, S_X, 799);
    push(FR + H * LN, S_FR, 1);
    push(2 * FR, S_X, 0);
    push(2 * FR, S_Y, 0);
    push(2 * FR, S_V, 1);
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    guard = 0;
    while (cyc != 2 * FR + 4 * LN + 400 && guard < 40000) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (guard >= 40000) begin
      n_chk++;
      n_fail++;
      $display("FAIL mid_reset_wait cyc=%0d required=%0d",
               cyc, 2 * FR + 4 * LN + 400);
    end

    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    push_reset_vec();
    push(H * LN - 1, S_FR, 0);
    push(H * LN, S_FR, 1);
    #1 reset_i = 1'b0;
    repeat (H * LN + 20) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    while (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unreached_%s cyc=%0d required=%0d",
               sig_name(q[0].sig), q[0].cyc, q[0].val);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the 800x600 @ 56 Hz VGA raster from the 36 MHz pixel clock.
- Drives the pixel coordinate and visible flag consumed by the layout remapping stage.
- Takes back that stage's colour, delays it, blanks it, and aligns it with hsync/vsync for the DAC pins.
- Issues a once-per-frame pulse so game logic can update its board during vertical blanking.

## Interface
- physical_width_p, 800, visible pixels per line
- physical_height_p, 600, visible lines per frame
- h_front_p / h_sync_p / h_back_p, 24 / 72 / 128, horizontal porch and sync widths in pixels
- v_front_p / v_sync_p / v_back_p, 1 / 2 / 22, vertical porch and sync widths in lines
- sync_pol_p, 1, active level of hsync_o/vsync_o
- bit_depth_p, 1, bits per colour channel
- pipe_delay_p, 1, cycles from coordinate out to colour in (0..4)

- clk_i  in  1  pixel clock, 36 MHz
- reset_i  in  1  synchronous, active-high reset
- vga_x_i  out  $clog2(physical_width_p)  current pixel column; 0 when not visible
- vga_y_i  out  $clog2(physical_height_p)  current line; 0 when not visible
- vga_v_i  out  1  current position is inside the visible area
- vga_r_o / vga_g_o / vga_b_o  in  bit_depth_p each  colour for the coordinate presented pipe_delay_p cycles earlier
- r_o / g_o / b_o  out  bit_depth_p each  colour to the DAC
- hsync_o / vsync_o  out  1  sync pins, aligned with r_o/g_o/b_o
- de_o  out  1  display enable, aligned with r_o/g_o/b_o
- frame_o  out  1  one-cycle pulse at the start of vertical blanking; not delayed

## Operation
- Totals:
  - H_TOTAL = width + h_front + h_sync + h_back = 1024.
  - V_TOTAL = height + v_front + v_sync + v_back = 625.
- Counters:
  - h_cnt has width $clog2(H_TOTAL) and v_cnt has width $clog2(V_TOTAL).
  - h_cnt increments every cycle and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on the h_cnt wrap, and wraps from V_TOTAL-1 to 0 on that same cycle.
- Visible flag: vis = (h_cnt < width) && (v_cnt < height).
  - vga_v_i = vis.
  - vga_x_i = vis ? h_cnt : 0, and vga_y_i = vis ? v_cnt : 0. Both are combinational from the counter registers.
- Raw hsync is active for h_cnt in [width+h_front, width+h_front+h_sync), i.e. 824..895.
- Raw vsync is active for v_cnt in [height+v_front, height+v_front+v_sync), i.e. 601..602, for whole lines.
- Alignment delay line:
  - vis, raw hsync and raw vsync each pass through a shift register of pipe_delay_p+1 stages.
  - Their outputs drive de_o, hsync_o and vsync_o; each sync pin is driven at sync_pol_p when active and at its inverse otherwise.
- Colour output stage:
  - A single register captures the colour inputs every cycle: r_o <= (vis delayed by pipe_delay_p) ? vga_r_o : 0. Same for g and b.
  - Blanking is therefore exact even if the upstream stage drives non-zero colour outside the visible area.
- frame_o = 1 exactly when h_cnt == 0 && v_cnt == height.

## Timing
- Reset:
  - The counters and every delay stage clear synchronously.
  - While reset_i is high, and on the first cycle after it falls:
    - h_cnt = v_cnt = 0, so vga_v_i = 1 and vga_x_i = vga_y_i = 0.
    - de_o = 0, r_o/g_o/b_o = 0, hsync_o = vsync_o = !sync_pol_p, frame_o = 0.
  - Pixel (0,0) is presented in the first cycle after reset release.
- Latency:
  - The coordinate presented in cycle t produces colour/de_o/hsync_o/vsync_o in cycle t+pipe_delay_p+1.
  - de_o and sync stay mutually aligned for every pipe_delay_p.
- Periods:
  - Line period: 1024 cycles.
  - Frame period: 640000 cycles.
  - vga_v_i is high for 800 consecutive cycles per visible line.
- Raster edges:
  - Simultaneous h/v wrap at (1023, 624) goes to (0, 0) in one cycle.
  - No pixel is dropped or repeated at any wrap.
- Reset mid-frame: the counters restart at (0,0) the next cycle, and the delay-line contents are discarded (outputs go to their reset values), with no partial-line glitch.

## Test plan
- Reset then free-run with pipe_delay_p=1:
  - Cycle 0 after release presents x=0, y=0, v=1.
  - Cycle 799 presents x=799; cycle 800 has v=0 and x=0.
  - Cycle 1024 presents y=1, x=0.
- Hsync timing: hsync_o active for exactly 72 cycles per line, first edge at cycle 824+2=826 after release; 1024-cycle period.
- Vsync and frame pulse:
  - frame_o first pulses at cycle 614400, then every 640000 cycles.
  - vsync_o is active from cycle 615424+2 for 2048 cycles.
  - de_o is low for all of lines 600..624.
- Colour alignment and blanking:
  - Upstream drives vga_r_o=1 only during the cycle after vga_x_i==5, and drives all colours =1 throughout the h_cnt range 800..1023.
  - Required: r_o=1 only in the cycle where de_o pixel index is 5, and r_o=g_o=b_o=0 throughout blanking.
- Wrap corner: run two full frames; check (1023,624) is followed by (0,0), and the count of v=1 cycles per frame is 480000.
- Reset mid-frame: assert reset_i at line 300, x=400 for 3 cycles; outputs show reset values, then (0,0) the cycle after release, and frame_o next fires 614400 cycles later.
